// File: rtl/reg_write_demux_pkg.sv
// reg_write_demux_pkg: shared register-file sizing used by the write demux and read-side selector
package reg_write_demux_pkg;
  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int SEL_W = 5;
endpackage

// File: rtl/decoder5_32.sv
// decoder5_32: 5-to-32 one-hot decoder with enable
module decoder5_32
  import reg_write_demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);
  always_comb onehot = en ? (NREGS'(1) << sel) : '0;
endmodule

// File: rtl/reg_write_demux.sv
// reg_write_demux: one-stage staged write into a register file with pending-write tracking
module reg_write_demux
  import reg_write_demux_pkg::*;
#(
  parameter int WIDTH_P = WIDTH,
  parameter int NREGS_P = NREGS
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [SEL_W-1:0]           wr_sel,
  input  logic [WIDTH_P-1:0]         wr_data,
  input  logic                       freeze,
  input  logic                       mark_valid,
  input  logic [SEL_W-1:0]           mark_sel,
  output logic [WIDTH_P*NREGS_P-1:0] q_flat,
  output logic [NREGS_P-1:0]         pending,
  output logic [15:0]                commit_count
);
  logic                 s_valid_q, s_valid_d;
  logic [SEL_W-1:0]     s_sel_q, s_sel_d;
  logic [WIDTH_P-1:0]   s_data_q, s_data_d;
  logic [WIDTH_P-1:0]   regs_q [NREGS_P];
  logic [WIDTH_P-1:0]   regs_d [NREGS_P];
  logic [NREGS_P-1:0]   pending_q, pending_d;
  logic [15:0]          count_q, count_d;
  logic [NREGS_P-1:0]   commit_oh, mark_oh;
  logic                 accept, commit;
  assign wr_ready = ~freeze;
  assign accept   = wr_valid & wr_ready;
  assign commit   = s_valid_q & ~freeze;
  decoder5_32 u_commit_dec (.sel(s_sel_q), .en(commit), .onehot(commit_oh));
  decoder5_32 u_mark_dec (.sel(mark_sel), .en(mark_valid), .onehot(mark_oh));
  always_comb begin
    s_valid_d = freeze ? s_valid_q : accept;
    s_sel_d   = accept ? wr_sel : s_sel_q;
    s_data_d  = accept ? wr_data : s_data_q;
    count_d   = commit ? count_q + 16'd1 : count_q;
    // mark is applied after the commit clear so a same-edge mark wins
    pending_d = ((pending_q & ~commit_oh) | mark_oh) & ~NREGS_P'(1);
    for (int k = 0; k < NREGS_P; k++)
      regs_d[k] = (k == 0) ? '0 : (commit_oh[k] ? s_data_q : regs_q[k]);
  end
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s_valid_q <= 1'b0;
      s_sel_q   <= '0;
      s_data_q  <= '0;
      pending_q <= '0;
      count_q   <= '0;
      for (int k = 0; k < NREGS_P; k++) regs_q[k] <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_sel_q   <= s_sel_d;
      s_data_q  <= s_data_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      for (int k = 0; k < NREGS_P; k++) regs_q[k] <= regs_d[k];
    end
  end
  always_comb begin
    q_flat = '0;
    for (int k = 0; k < NREGS_P; k++) q_flat[k*WIDTH_P +: WIDTH_P] = regs_q[k];
  end
  assign pending      = pending_q;
  assign commit_count = count_q;
endmodule

// File: tb/tb_reg_write_demux.sv
// tb_reg_write_demux: directed self-checking bench for reg_write_demux
module tb_reg_write_demux;
  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [4:0]    wr_sel = '0;
  logic [31:0]   wr_data = '0;
  logic          freeze = 1'b0;
  logic          mark_valid = 1'b0;
  logic [4:0]    mark_sel = '0;
  logic [1023:0] q_flat;
  logic [31:0]   pending;
  logic [15:0]   commit_count;
  logic [1023:0] exp_flat;
  int n_cmp = 0;
  int n_bad = 0;

  reg_write_demux dut (
    .clk(clk), .clr_n(clr_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .freeze(freeze),
    .mark_valid(mark_valid), .mark_sel(mark_sel), .q_flat(q_flat),
    .pending(pending), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input int k);
    return q_flat[k*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    #1;
    clr_n = 1'b1;
  endtask

  task automatic put(input logic [4:0] s, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_sel   = s;
    wr_data  = d;
  endtask

  initial begin
    tick();
    chk("rst_q", q_flat, '0);
    chk("rst_pending", pending, '0);
    chk("rst_count", commit_count, 16'd0);
    chk("rst_ready", wr_ready, 1'b1);
    clr_n = 1'b1;

    put(5'd5, 32'hDEADBEEF);
    tick();
    wr_valid = 1'b0;
    chk("no_bypass", rd(5), 32'h0);
    tick();
    exp_flat = '0;
    exp_flat[5*32 +: 32] = 32'hDEADBEEF;
    chk("w5_flat", q_flat, exp_flat);
    chk("w5_count", commit_count, 16'd1);

    do_reset();
    put(5'd3, 32'h33333333);
    tick();
    put(5'd4, 32'h44444444);
    tick();
    chk("b2b_r3", rd(3), 32'h33333333);
    chk("b2b_r4_pre", rd(4), 32'h0);
    put(5'd5, 32'h55555555);
    tick();
    chk("b2b_r4", rd(4), 32'h44444444);
    chk("b2b_r5_pre", rd(5), 32'h0);
    wr_valid = 1'b0;
    tick();
    chk("b2b_r5", rd(5), 32'h55555555);
    chk("b2b_count", commit_count, 16'd3);

    put(5'd7, 32'h07070707);
    tick();
    wr_valid = 1'b0;
    freeze = 1'b1;
    #1;
    chk("frz_ready", wr_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("frz_r7_hold", rd(7), 32'h0);
    end
    chk("frz_count", commit_count, 16'd3);
    freeze = 1'b0;
    #1;
    chk("unfrz_ready", wr_ready, 1'b1);
    tick();
    chk("unfrz_r7", rd(7), 32'h07070707);
    chk("unfrz_count", commit_count, 16'd4);

    put(5'd0, 32'hFFFFFFFF);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("r0_zero", rd(0), 32'h0);
    chk("r0_count", commit_count, 16'd5);

    mark_valid = 1'b1;
    mark_sel = 5'd9;
    tick();
    mark_valid = 1'b0;
    chk("mark9", pending, 32'h0000_0200);
    put(5'd9, 32'h99999999);
    tick();
    wr_valid = 1'b0;
    mark_valid = 1'b1;
    mark_sel = 5'd9;
    tick();
    mark_valid = 1'b0;
    chk("remark9_pending", pending, 32'h0000_0200);
    chk("remark9_r9", rd(9), 32'h99999999);
    put(5'd9, 32'h19191919);
    tick();
    wr_valid = 1'b0;
    tick();
    chk("clear9", pending, 32'h0);
    chk("clear9_r9", rd(9), 32'h19191919);
    mark_valid = 1'b1;
    mark_sel = 5'd0;
    tick();
    chk("mark0_ignored", pending, 32'h0);
    freeze = 1'b1;
    mark_sel = 5'd10;
    tick();
    mark_valid = 1'b0;
    freeze = 1'b0;
    chk("mark_frozen", pending, 32'h0000_0400);

    do_reset();
    put(5'd12, 32'hCCCCCCCC);
    tick();
    wr_valid = 1'b0;
    clr_n = 1'b0;
    #1;
    chk("async_count", commit_count, 16'd0);
    chk("async_pending", pending, 32'h0);
    chk("async_q", q_flat, '0);
    clr_n = 1'b1;
    tick();
    tick();
    chk("discard_r12", rd(12), 32'h0);
    chk("discard_count", commit_count, 16'd0);

    wr_valid = 1'b1;
    wr_sel = 5'd1;
    for (int i = 0; i < 65536; i++) begin
      wr_data = i;
      tick();
    end
    wr_valid = 1'b0;
    chk("wrap_ffff", commit_count, 16'hFFFF);
    tick();
    chk("wrap_zero", commit_count, 16'h0000);
    chk("wrap_r1", rd(1), 32'd65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
